mips_harvard_bus_bridge: RTL and testbench

MIPS_HARVARD_BUS_BRIDGE -- requirements
Module: mips_harvard_bus_bridge

---
 rtl/mips_bus_pkg.sv | 13 +
 rtl/mips_fetch_buffer.sv | 45 ++++
 rtl/mips_harvard_bus_bridge.sv | 165 ++++++++++++++++
 tb/tb_mips_harvard_bus_bridge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS Harvard-to-single-bus bridge.
package mips_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/mips_fetch_buffer.sv
// Single-entry buffer holding the most recently fetched instruction word.
module mips_fetch_buffer
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inval_en,
    input  logic [ADDR_W-1:0] inval_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
        end else if (inval_en && (inval_addr == tag_q)) begin
            valid_q <= 1'b0;
        end
    end

    // Tag and data carry no reset: they are only observed while valid_q is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q  <= fill_addr;
            data_q <= fill_data;
        end
    end

    assign hit      = valid_q && (lookup_addr == tag_q);
    assign hit_data = data_q;

endmodule

// File: rtl/mips_harvard_bus_bridge.sv
// Merges MIPS instruction and data ports onto one waitrequest-style bus.
// Optional single-word fetch buffer enabled by defining BRIDGE_FETCH_BUFFER_EN.
module mips_harvard_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int BE_W   = DATA_W / 8
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] instr_address,
    input  logic              instr_read,
    output logic [DATA_W-1:0] instr_readdata,
    output logic              instr_ack,
    input  logic [ADDR_W-1:0] data_address,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [DATA_W-1:0] data_writedata,
    input  logic [BE_W-1:0]   data_byteenable,
    output logic [DATA_W-1:0] data_readdata,
    output logic              data_ack,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest
);

    localparam int OFF_W = $clog2(BE_W);

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    bridge_state_t     state_q, state_d;
    logic              read_d, write_d, iack_d, dack_d;
    logic [ADDR_W-1:0] address_d;
    logic [BE_W-1:0]   be_d;
    logic [DATA_W-1:0] wdata_d, ird_d, drd_d;
    logic              data_pend, instr_pend;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;

`ifdef BRIDGE_FETCH_BUFFER_EN
    logic fill_en, inval_en;

    assign fill_en  = (state_q == FETCH) && !waitrequest;
    assign inval_en = (state_q == DATA) && write && !waitrequest;

    mips_fetch_buffer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .fill_en    (fill_en),
        .fill_addr  (address),
        .fill_data  (readdata),
        .inval_en   (inval_en),
        .inval_addr (address),
        .lookup_addr(word_align(instr_address)),
        .hit        (buf_hit),
        .hit_data   (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // A request still visible during its own ack cycle is the one just served.
    assign data_pend  = (data_read || data_write) && !data_ack;
    assign instr_pend = instr_read && !instr_ack;

    always_comb begin
        state_d   = state_q;
        read_d    = read;
        write_d   = write;
        address_d = address;
        be_d      = byteenable;
        wdata_d   = writedata;
        iack_d    = 1'b0;
        dack_d    = 1'b0;
        ird_d     = instr_readdata;
        drd_d     = data_readdata;
        case (state_q)
            IDLE: begin
                if (data_pend) begin
                    state_d   = DATA;
                    address_d = word_align(data_address);
                    be_d      = data_byteenable;
                    if (data_write) begin
                        write_d = 1'b1;
                        wdata_d = data_writedata;
                    end else begin
                        read_d = 1'b1;
                    end
                end else if (instr_pend) begin
                    if (buf_hit) begin
                        iack_d = 1'b1;
                        ird_d  = buf_data;
                    end else begin
                        state_d   = FETCH;
                        read_d    = 1'b1;
                        address_d = word_align(instr_address);
                        be_d      = '1;
                    end
                end
            end
            FETCH: begin
                if (!waitrequest) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    iack_d  = 1'b1;
                    ird_d   = readdata;
                end
            end
            DATA: begin
                if (!waitrequest) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    dack_d  = 1'b1;
                    if (read) begin
                        drd_d = readdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            read           <= 1'b0;
            write          <= 1'b0;
            instr_ack      <= 1'b0;
            data_ack       <= 1'b0;
            address        <= '0;
            byteenable     <= '0;
            writedata      <= '0;
            instr_readdata <= '0;
            data_readdata  <= '0;
        end else begin
            state_q        <= state_d;
            read           <= read_d;
            write          <= write_d;
            instr_ack      <= iack_d;
            data_ack       <= dack_d;
            address        <= address_d;
            byteenable     <= be_d;
            writedata      <= wdata_d;
            instr_readdata <= ird_d;
            data_readdata  <= drd_d;
        end
    end

endmodule

// File: tb/tb_mips_harvard_bus_bridge.sv
// Directed bench for mips_harvard_bus_bridge (optionally with BRIDGE_FETCH_BUFFER_EN).
module tb_mips_harvard_bus_bridge;
    import mips_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address, instr_readdata;
    logic        instr_read, instr_ack;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_read, data_write, data_ack;
    logic [3:0]  data_byteenable, byteenable;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_harvard_bus_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .instr_address  (instr_address),
        .instr_read     (instr_read),
        .instr_readdata (instr_readdata),
        .instr_ack      (instr_ack),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_byteenable(data_byteenable),
        .data_readdata  (data_readdata),
        .data_ack       (data_ack),
        .address        (address),
        .read           (read),
        .write          (write),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .readdata       (readdata),
        .waitrequest    (waitrequest)
    );

    typedef struct {
        string       name;
        logic        ii, rd, wr;
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic [31:0] rdat;
        int          w;
        int          exp_lat;
        logic [31:0] exp_a;
        logic [3:0]  exp_be;
        logic        exp_rd, exp_wr;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          lat;
        int          strobes;
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic        saw_rd, saw_wr, stable, idle_at_ack, iack, dack, pulse1;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic ii, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] rdat, input int w, output res_t r);
        r = '{lat: -1, strobes: 0, a: '0, wd: '0, be: '0, saw_rd: 0, saw_wr: 0,
              stable: 1, idle_at_ack: 0, iack: 0, dack: 0, pulse1: 0};
        instr_read = ii; data_read = rd; data_write = wr;
        instr_address = a; data_address = a; data_writedata = wd; data_byteenable = be;
        readdata = rdat; waitrequest = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (read || write) begin
                r.strobes++;
                if (r.strobes == 1) begin
                    r.a = address; r.be = byteenable; r.wd = writedata;
                end else if (address !== r.a || byteenable !== r.be || writedata !== r.wd) begin
                    r.stable = 1'b0;
                end
                r.saw_rd |= read;
                r.saw_wr |= write;
                waitrequest = (r.strobes <= w);
            end
            if (instr_ack || data_ack) begin
                r.lat = n;
                r.iack = instr_ack;
                r.dack = data_ack;
                r.idle_at_ack = !read && !write;
                break;
            end
        end
        instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0; waitrequest = 1'b0;
        @(posedge clk); #1;
        r.pulse1 = !instr_ack && !data_ack;
    endtask

    vec_t vecs[5];
    res_t r;
    int   first_d, first_i;
    logic coinc, spurious;

    initial begin
        vecs[0] = '{"fetch_bfc", 1, 0, 0, 32'hBFC0_0000, 32'h0, 4'h0, 32'h2402_0005, 0,
                    2, 32'hBFC0_0000, 4'hF, 1, 0, 32'h2402_0005};
        vecs[1] = '{"store_1003", 0, 0, 1, 32'h0000_1003, 32'hDEAD_BEEF, 4'hF, 32'h0, 3,
                    5, 32'h0000_1000, 4'hF, 0, 1, 32'hDEAD_BEEF};
        vecs[2] = '{"load_2006", 0, 1, 0, 32'h0000_2006, 32'h0, 4'hC, 32'h1234_5678, 1,
                    3, 32'h0000_2004, 4'hC, 1, 0, 32'h1234_5678};
        vecs[3] = '{"fetch_wait2", 1, 0, 0, 32'h0040_0011, 32'h0, 4'h0, 32'h8FBF_0010, 2,
                    4, 32'h0040_0010, 4'hF, 1, 0, 32'h8FBF_0010};
        vecs[4] = '{"rdwr_both", 0, 1, 1, 32'h0000_3002, 32'hCAFE_F00D, 4'h1, 32'h5555_5555, 0,
                    2, 32'h0000_3000, 4'h1, 0, 1, 32'hCAFE_F00D};

        reset = 1'b1;
        instr_read = 0; data_read = 0; data_write = 0; waitrequest = 0;
        instr_address = '0; data_address = '0; data_writedata = '0; data_byteenable = '0;
        readdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.strobes", {30'b0, read, write}, 32'h0);
        chk("reset.acks", {30'b0, instr_ack, data_ack}, 32'h0);
        chk("reset.address", address, 32'h0);
        chk("reset.be_wd", {28'b0, byteenable} | writedata, 32'h0);
        chk("reset.readdata", instr_readdata | data_readdata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            do_req(vecs[i].ii, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].be,
                   vecs[i].rdat, vecs[i].w, r);
            chk({vecs[i].name, ".lat"}, 32'(r.lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, ".strobes"}, 32'(r.strobes), 32'(vecs[i].w + 1));
            chk({vecs[i].name, ".addr"}, r.a, vecs[i].exp_a);
            chk({vecs[i].name, ".be"}, 32'(r.be), 32'(vecs[i].exp_be));
            chk({vecs[i].name, ".kind"}, {30'b0, r.saw_rd, r.saw_wr},
                {30'b0, vecs[i].exp_rd, vecs[i].exp_wr});
            chk({vecs[i].name, ".stable"}, 32'(r.stable), 32'd1);
            chk({vecs[i].name, ".drop"}, 32'(r.idle_at_ack), 32'd1);
            chk({vecs[i].name, ".ackport"}, {30'b0, r.iack, r.dack},
                vecs[i].ii ? 32'h2 : 32'h1);
            chk({vecs[i].name, ".pulse"}, 32'(r.pulse1), 32'd1);
            if (vecs[i].wr)
                chk({vecs[i].name, ".wdata"}, r.wd, vecs[i].exp_data);
            else if (vecs[i].ii)
                chk({vecs[i].name, ".rdata"}, instr_readdata, vecs[i].exp_data);
            else
                chk({vecs[i].name, ".rdata"}, data_readdata, vecs[i].exp_data);
        end
        chk("hold.data_readdata", data_readdata, 32'h1234_5678);
        chk("hold.instr_readdata", instr_readdata, 32'h8FBF_0010);

        // Data and instruction requests raised together.
        instr_address = 32'h0000_0200; data_address = 32'h0000_0300; data_byteenable = 4'hF;
        instr_read = 1'b1; data_read = 1'b1; data_write = 1'b0; waitrequest = 1'b0;
        first_d = -1; first_i = -1; coinc = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (read) readdata = (address == 32'h0000_0300) ? 32'h0D0D_0D0D : 32'h1A1A_1A1A;
            if (instr_ack && data_ack) coinc = 1'b1;
            if (data_ack && first_d < 0) begin first_d = n; data_read = 1'b0; end
            if (instr_ack && first_i < 0) begin first_i = n; instr_read = 1'b0; end
            if (first_d > 0 && first_i > 0) break;
        end
        instr_read = 1'b0; data_read = 1'b0;
        chk("prio.data_ack_cycle", 32'(first_d), 32'd2);
        chk("prio.instr_ack_cycle", 32'(first_i), 32'd4);
        chk("prio.coincident", 32'(coinc), 32'd0);
        chk("prio.data_readdata", data_readdata, 32'h0D0D_0D0D);
        chk("prio.instr_readdata", instr_readdata, 32'h1A1A_1A1A);
        @(posedge clk); #1;

        // Reset while a load is stalled.
        data_address = 32'h0000_0400; data_read = 1'b1; waitrequest = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid.read_before", 32'(read), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid.read", 32'(read), 32'd0);
        chk("rst_mid.ack", {30'b0, instr_ack, data_ack}, 32'h0);
        chk("rst_mid.state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_mid.data_readdata", data_readdata, 32'h0);
        data_read = 1'b0; waitrequest = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        spurious = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (instr_ack || data_ack || read || write) spurious = 1'b1;
        end
        chk("rst_mid.quiet_after", 32'(spurious), 32'd0);

        // Fetch buffer hit and invalidation by a store.
        do_req(1, 0, 0, 32'h100, 32'h0, 4'h0, 32'hAAAA_0001, 0, r);
        chk("fb.fetch1.lat", 32'(r.lat), 32'd2);
        chk("fb.fetch1.data", instr_readdata, 32'hAAAA_0001);
        do_req(1, 0, 0, 32'h100, 32'h0, 4'h0, 32'h1111_1111, 0, r);
`ifdef BRIDGE_FETCH_BUFFER_EN
        chk("fb.fetch2.lat", 32'(r.lat), 32'd1);
        chk("fb.fetch2.strobes", 32'(r.strobes), 32'd0);
        chk("fb.fetch2.data", instr_readdata, 32'hAAAA_0001);
`else
        chk("fb.fetch2.lat", 32'(r.lat), 32'd2);
        chk("fb.fetch2.strobes", 32'(r.strobes), 32'd1);
        chk("fb.fetch2.data", instr_readdata, 32'h1111_1111);
`endif
        do_req(0, 0, 1, 32'h100, 32'h0000_0042, 4'hF, 32'h0, 0, r);
        chk("fb.store.lat", 32'(r.lat), 32'd2);
        do_req(1, 0, 0, 32'h100, 32'h0, 4'h0, 32'h2222_2222, 0, r);
        chk("fb.fetch3.lat", 32'(r.lat), 32'd2);
        chk("fb.fetch3.strobes", 32'(r.strobes), 32'd1);
        chk("fb.fetch3.data", instr_readdata, 32'h2222_2222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
